// File: rtl/brm_pkg.sv
// ---------------------------------------------------------------------------
// brm_pkg
//   Shared definitions for the binary-rate-multiplier (BRM) generator and
//   decoder blocks.
//
//   Contents:
//     BRM_WIDTH        default rate code width
//     brm_dec_state_t  decoder control state
//     brm_window_len   number of enabled cycles in one BRM period
// ---------------------------------------------------------------------------
package brm_pkg;

  localparam int BRM_WIDTH = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } brm_dec_state_t;

  // One BRM period spans 2**width enabled cycles.
  function automatic int brm_window_len(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/brm_window_counter.sv
// ---------------------------------------------------------------------------
// brm_window_counter
//   WIDTH-bit enabled up-counter that wraps modulo 2**WIDTH, with an
//   asynchronous active-low reset and a synchronous clear. Shared between the
//   BRM generator and the rate decoder.
//
//   Ports:
//     clk       in   clock, rising edge
//     clr_n     in   asynchronous active-low reset
//     sync_clr  in   synchronous clear (wins over en)
//     en        in   advance by one this edge
//     cnt       out  WIDTH  current count
//     tc        out  count sits at its last value (2**WIDTH-1); the next
//                    enabled edge wraps it to 0
// ---------------------------------------------------------------------------
module brm_window_counter
  import brm_pkg::*;
#(
  parameter int WIDTH = BRM_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sync_clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam int               WIN_LEN  = brm_window_len(WIDTH);
  localparam logic [WIDTH-1:0] WIN_LAST = WIDTH'(WIN_LEN - 1);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == WIN_LAST);

endmodule

// File: rtl/brm_rate_decoder.sv
// ---------------------------------------------------------------------------
// brm_rate_decoder
//   Receiving end of a BRM pulse stream. Counts qualified pulses over one
//   full 2**WIDTH enabled-cycle window and reports the recovered rate code.
//   Runs continuously from a start request until stop or reset.
//
//   Ports:
//     clk          in   clock, all state on rising edge
//     clr_n        in   asynchronous active-low reset
//     start        in   one-cycle request: zero counters, (re)enter RUN
//     stop         in   one-cycle request: abort window, go IDLE
//     count_en     in   window advance qualifier
//     pulse_in     in   one BRM output pulse this cycle (only when count_en)
//     rate_out     out  WIDTH+1  pulse count of last completed window
//     rate_valid   out  one-cycle strobe, rate_out has just been updated
//     busy         out  decoder is in RUN
//     window_pos   out  WIDTH  current window counter
//     state_dbg    out  raw control state (0 = IDLE, 1 = RUN)
//
//   Optional build macro BRM_RATE_DECODER_CHECK_EN adds:
//     expect_b     in   WIDTH  expected rate code
//     mismatch     out  sticky: some window result differed from expect_b
//     mismatch_cnt out  8  number of differing windows, saturates at 255
//
//   Handshake: there is no back-pressure. rate_valid is a pure strobe, high
//   for exactly the one cycle after a window completes; rate_out holds its
//   value until the next completed window, so a consumer may sample it at
//   any time and treat rate_valid only as a "new value" marker.
// ---------------------------------------------------------------------------
module brm_rate_decoder
  import brm_pkg::*;
#(
  parameter int WIDTH = BRM_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             stop,
  input  logic             count_en,
  input  logic             pulse_in,
`ifdef BRM_RATE_DECODER_CHECK_EN
  input  logic [WIDTH-1:0] expect_b,
  output logic             mismatch,
  output logic [7:0]       mismatch_cnt,
`endif
  output logic [WIDTH:0]   rate_out,
  output logic             rate_valid,
  output logic             busy,
  output logic [WIDTH-1:0] window_pos,
  output logic             state_dbg
);

  brm_dec_state_t   state;
  brm_dec_state_t   state_next;

  logic [WIDTH-1:0] window_cnt;
  logic             window_tc;
  logic [WIDTH:0]   pulse_cnt;
  logic [WIDTH:0]   new_rate;
  logic             advance;
  logic             win_end;

  // start and stop both override counting on their edge; start wins over
  // stop in the state logic, and both zero the counters.
  assign advance  = (state == RUN) && count_en && !start && !stop;
  assign win_end  = advance && window_tc;
  // The pulse arriving on the window-end edge still belongs to the window.
  assign new_rate = pulse_cnt + {{WIDTH{1'b0}}, pulse_in};

  // ---- state register ----
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start)     state_next = RUN;
        else if (stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---- state-decoded outputs ----
  always_comb begin
    busy      = 1'b0;
    state_dbg = 1'b0;
    if (state == RUN) begin
      busy      = 1'b1;
      state_dbg = 1'b1;
    end
  end

  // Window position wraps naturally at the window end, so only start/stop
  // need an explicit clear.
  brm_window_counter #(
    .WIDTH (WIDTH)
  ) u_window_counter (
    .clk      (clk),
    .clr_n    (clr_n),
    .sync_clr (start | stop),
    .en       (advance),
    .cnt      (window_cnt),
    .tc       (window_tc)
  );

  assign window_pos = window_cnt;

  // WIDTH+1 bits so a full window of pulses (unity rate) does not wrap.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pulse_cnt <= '0;
    end else if (start || stop || win_end) begin
      pulse_cnt <= '0;
    end else if (advance) begin
      pulse_cnt <= new_rate;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rate_out   <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= win_end;
      if (win_end) begin
        rate_out <= new_rate;
      end
    end
  end

`ifdef BRM_RATE_DECODER_CHECK_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else if (start) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else if (win_end && (new_rate != {1'b0, expect_b})) begin
      mismatch <= 1'b1;
      if (mismatch_cnt != 8'hFF) begin
        mismatch_cnt <= mismatch_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_brm_rate_decoder.sv
// ---------------------------------------------------------------------------
// tb_brm_rate_decoder
//   Self-checking bench for brm_rate_decoder (WIDTH = 6). A small reference
//   model of the window/pulse counting pushes each expected window result to
//   exp_q as stimulus is driven; a monitor pops and compares whenever the
//   DUT strobes rate_valid. Define BRM_RATE_DECODER_CHECK_EN to also cover
//   the mismatch checker.
// ---------------------------------------------------------------------------
module tb_brm_rate_decoder;

  localparam int W   = 6;
  localparam int WIN = 1 << W;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  logic         start;
  logic         stop;
  logic         count_en;
  logic         pulse_in;
  logic [W:0]   rate_out;
  logic         rate_valid;
  logic         busy;
  logic [W-1:0] window_pos;
  logic         state_dbg;
`ifdef BRM_RATE_DECODER_CHECK_EN
  logic [W-1:0] expect_b;
  logic         mismatch;
  logic [7:0]   mismatch_cnt;
`endif

  brm_rate_decoder #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .start        (start),
    .stop         (stop),
    .count_en     (count_en),
    .pulse_in     (pulse_in),
`ifdef BRM_RATE_DECODER_CHECK_EN
    .expect_b     (expect_b),
    .mismatch     (mismatch),
    .mismatch_cnt (mismatch_cnt),
`endif
    .rate_out     (rate_out),
    .rate_valid   (rate_valid),
    .busy         (busy),
    .window_pos   (window_pos),
    .state_dbg    (state_dbg)
  );

  // ---- scoreboard ----
  logic [W:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model ----
  bit m_run   = 1'b0;
  int m_win   = 0;
  int m_pc    = 0;
  bit m_valid = 1'b0;

  // BRM pulse for phase p: phases with exactly k trailing ones occur
  // 2**(W-1-k) times per window and carry bit W-1-k of the rate code.
  function automatic bit brm_pulse(input logic [W-1:0] b, input int p);
    int k = 0;
    while (k < W && p[k]) k++;
    return (k < W) ? b[W-1-k] : 1'b0;
  endfunction

  // ---- driver ----
  task automatic step(input bit en, input bit p);
    count_en = en;
    pulse_in = p;
    m_valid  = 1'b0;
    if (start) begin
      m_run = 1'b1; m_win = 0; m_pc = 0;
    end else if (stop) begin
      m_run = 1'b0; m_win = 0; m_pc = 0;
    end else if (m_run && en) begin
      if (m_win == WIN - 1) begin
        exp_q.push_back((W+1)'(m_pc + int'(p)));
        m_valid = 1'b1;
        m_win = 0; m_pc = 0;
      end else begin
        m_win++;
        m_pc += int'(p);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    check("window_pos", int'(window_pos), m_win);
    check("busy", int'(busy), int'(m_run));
    check("rate_valid", int'(rate_valid), int'(m_valid));
  endtask

  task automatic run_brm(input logic [W-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(1'b1, brm_pulse(b, m_win));
  endtask

  task automatic do_start(input bit also_stop);
    start = 1'b1;
    stop  = also_stop;
    step(1'b1, 1'b0);
  endtask

  // ---- monitor ----
  always @(negedge clk) begin
    if (clr_n && rate_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else check("rate_out_sb", int'(rate_out), int'(exp_q.pop_front()));
    end
  end

  // ---- watchdog ----
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---- stimulus ----
  initial begin
    clr_n = 1'b0; start = 1'b0; stop = 1'b0; count_en = 1'b0; pulse_in = 1'b0;
`ifdef BRM_RATE_DECODER_CHECK_EN
    expect_b = 6'd42;
`endif
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;

    check("rst_rate_out", int'(rate_out), 0);
    check("rst_rate_valid", int'(rate_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_window_pos", int'(window_pos), 0);
    check("rst_state_dbg", int'(state_dbg), 0);

    // Rate 42: valid exactly 64 edges after the start edge.
    do_start(1'b0);
    check("run_state_dbg", int'(state_dbg), 1);
    run_brm(6'd42, WIN - 1);
    check("r42_not_yet", int'(rate_valid), 0);
    check("r42_pos63", int'(window_pos), WIN - 1);
    run_brm(6'd42, 1);
    check("r42_valid", int'(rate_valid), 1);
    check("r42_rate", int'(rate_out), 42);
    run_brm(6'd42, WIN);
    check("r42_second", int'(rate_out), 42);

    // B = 0: no pulses.
    do_start(1'b0);
    run_brm(6'd0, WIN);
    check("b0_rate", int'(rate_out), 0);

    // Gated enable, pulses only while count_en = 0.
    do_start(1'b0);
    for (int i = 0; i < 2 * WIN; i++) begin
      step(i % 2 == 1, i % 2 == 0);
      if (i == 2 * WIN - 2) check("gated_not_yet", int'(rate_valid), 0);
    end
    check("gated_valid128", int'(rate_valid), 1);
    check("gated_rate", int'(rate_out), 0);

    // pulse_in held high: full count, no wrap.
    do_start(1'b0);
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b1);
    check("unity_rate", int'(rate_out), WIN);

    // Abort at window_pos 30; IDLE then ignores traffic.
    while (m_win != 30) step(1'b1, 1'b1);
    stop = 1'b1;
    step(1'b1, 1'b1);
    check("abort_busy", int'(busy), 0);
    check("abort_rate", int'(rate_out), WIN);
    repeat (10) step(1'b1, 1'b1);
    stop = 1'b1;
    step(1'b1, 1'b1);
    check("idle_rate", int'(rate_out), WIN);

    // start and stop together: start wins.
    do_start(1'b1);
    check("ss_busy", int'(busy), 1);
    check("ss_pos", int'(window_pos), 0);

    // stop on the window-end edge still aborts without an update.
    while (m_win != WIN - 1) step(1'b1, 1'b1);
    stop = 1'b1;
    step(1'b1, 1'b1);
    check("stop_end_busy", int'(busy), 0);
    check("stop_end_rate", int'(rate_out), WIN);

    // Restart mid-window: partial window produces nothing.
    do_start(1'b0);
    repeat (20) step(1'b1, 1'b1);
    do_start(1'b0);
    run_brm(6'd21, WIN);
    check("restart_rate", int'(rate_out), 21);

    // Reset mid-window at window_pos 40.
    while (m_win != 40) step(1'b1, 1'b1);
    clr_n = 1'b0;
    #1;
    check("mrst_rate_out", int'(rate_out), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_window_pos", int'(window_pos), 0);
    check("mrst_rate_valid", int'(rate_valid), 0);
    m_run = 1'b0; m_win = 0; m_pc = 0;
    exp_q.delete();
    @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (5) step(1'b1, 1'b1);
    check("post_rst_idle", int'(busy), 0);

`ifdef BRM_RATE_DECODER_CHECK_EN
    expect_b = 6'd42;
    do_start(1'b0);
    run_brm(6'd41, WIN);
    check("chk_rate", int'(rate_out), 41);
    check("chk_mismatch1", int'(mismatch), 1);
    check("chk_cnt1", int'(mismatch_cnt), 1);
    run_brm(6'd41, WIN);
    check("chk_cnt2", int'(mismatch_cnt), 2);
    do_start(1'b0);
    check("chk_clr_mismatch", int'(mismatch), 0);
    check("chk_clr_cnt", int'(mismatch_cnt), 0);
    run_brm(6'd42, WIN);
    check("chk_match", int'(mismatch), 0);
`endif

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
